// File: rtl/block_pixel_streamer.sv
// Block-order pixel transmitter: validates N/M geometry, then reads an N x N raster image
// from a synchronous RAM and streams it as M x M blocks with a two-stage read pipeline.
module block_pixel_streamer #(
    parameter int unsigned Data_Depth = 8,
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned SIZE_W     = 10,
    parameter int unsigned M_W        = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SIZE_W-1:0]     img_size,
    input  logic [M_W-1:0]        blk_size,
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [Data_Depth-1:0] mem_rdata,
    output logic                  new_pixel,
    output logic [Data_Depth-1:0] Pixel_Data,
    output logic [M_W-1:0]        M,
    output logic                  Image_Done,
    output logic                  busy,
    output logic                  cfg_err
);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StErr,
        StStream,
        StDrain,
        StDone
    } state_e;

    localparam logic [ADDR_W-1:0] AddrOne = 1;
    localparam logic [SIZE_W-1:0] SizeOne = 1;
    localparam logic [M_W-1:0]    MOne    = 1;

    state_e                r_state;
    state_e                w_state_next;

    logic [SIZE_W-1:0]     r_n;
    logic [M_W-1:0]        r_m;
    logic [SIZE_W-1:0]     r_rem;
    logic [SIZE_W-1:0]     r_kpb;
    logic [ADDR_W-1:0]     r_addr;
    logic [M_W-1:0]        r_col;
    logic [M_W-1:0]        r_row;
    logic [SIZE_W-1:0]     r_bcol;
    logic [SIZE_W-1:0]     r_strip;
    logic                  r_rd_v1;
    logic                  r_new_pix;
    logic [Data_Depth-1:0] r_pix;

    logic [SIZE_W-1:0]     w_m_sz;
    logic [ADDR_W-1:0]     w_n_ext;
    logic [ADDR_W-1:0]     w_m_ext;
    logic [ADDR_W-1:0]     w_row_step;
    logic [ADDR_W-1:0]     w_blk_back;
    logic [M_W-1:0]        w_m_last;
    logic [SIZE_W-1:0]     w_kpb_last;
    logic                  w_geom_bad;
    logic                  w_rd_en;
    logic                  w_last;

    assign w_m_sz     = SIZE_W'(r_m);
    assign w_n_ext    = ADDR_W'(r_n);
    assign w_m_ext    = ADDR_W'(r_m);
    assign w_row_step = w_n_ext - w_m_ext + AddrOne;
    // Jump from the end of one block back to the top-right neighbour block.
    assign w_blk_back = w_n_ext * (w_m_ext - AddrOne) - AddrOne;
    assign w_m_last   = r_m - MOne;
    assign w_kpb_last = r_kpb - SizeOne;
    assign w_geom_bad = (r_m == '0) || (r_n == '0) || (w_m_sz > r_n);
    assign w_rd_en    = (r_state == StStream);
    assign w_last     = (r_strip == w_kpb_last) && (r_bcol == w_kpb_last) &&
                        (r_row == w_m_last) && (r_col == w_m_last);

    assign mem_rd_en  = w_rd_en;
    assign mem_addr   = r_addr;
    assign new_pixel  = r_new_pix;
    assign Pixel_Data = r_pix;
    assign M          = r_m;
    assign Image_Done = (r_state == StDone);
    assign cfg_err    = (r_state == StErr);
    assign busy       = (r_state != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (start) w_state_next = StCheck;
            end
            StCheck: begin
                if (w_geom_bad) begin
                    w_state_next = StErr;
                end else if (r_rem >= w_m_sz) begin
                    w_state_next = StCheck;
                end else if (r_rem == '0) begin
                    w_state_next = StStream;
                end else begin
                    w_state_next = StErr;
                end
            end
            StErr:    w_state_next = StIdle;
            StStream: begin
                if (w_last) w_state_next = StDrain;
            end
            // Last read is registered once more before it appears as a pixel.
            StDrain: begin
                if (!r_rd_v1) w_state_next = StDone;
            end
            StDone:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n       <= '0;
            r_m       <= '0;
            r_rem     <= '0;
            r_kpb     <= '0;
            r_addr    <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_bcol    <= '0;
            r_strip   <= '0;
            r_rd_v1   <= 1'b0;
            r_new_pix <= 1'b0;
            r_pix     <= '0;
        end else begin
            r_rd_v1   <= w_rd_en;
            r_new_pix <= r_rd_v1;
            if (r_rd_v1) r_pix <= mem_rdata;

            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_n     <= img_size;
                        r_m     <= blk_size;
                        r_rem   <= img_size;
                        r_kpb   <= '0;
                        r_addr  <= '0;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_bcol  <= '0;
                        r_strip <= '0;
                    end
                end
                StCheck: begin
                    if (!w_geom_bad && (r_rem >= w_m_sz)) begin
                        r_rem <= r_rem - w_m_sz;
                        r_kpb <= r_kpb + SizeOne;
                    end
                end
                StStream: begin
                    if (!w_last) begin
                        if (r_col != w_m_last) begin
                            r_addr <= r_addr + AddrOne;
                            r_col  <= r_col + MOne;
                        end else if (r_row != w_m_last) begin
                            r_addr <= r_addr + w_row_step;
                            r_col  <= '0;
                            r_row  <= r_row + MOne;
                        end else if (r_bcol != w_kpb_last) begin
                            r_addr <= r_addr - w_blk_back;
                            r_col  <= '0;
                            r_row  <= '0;
                            r_bcol <= r_bcol + SizeOne;
                        end else begin
                            r_addr  <= r_addr + AddrOne;
                            r_col   <= '0;
                            r_row   <= '0;
                            r_bcol  <= '0;
                            r_strip <= r_strip + SizeOne;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_block_pixel_streamer.sv
// Self-checking bench for block_pixel_streamer: table vectors, random geometries against a
// block-order reference model, plus mid-stream start and mid-stream reset sequences.
module tb_block_pixel_streamer;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 20;
    localparam int unsigned SW = 10;
    localparam int unsigned MW = 7;

    logic          clk;
    logic          rst;
    logic          start;
    logic [SW-1:0] img_size;
    logic [MW-1:0] blk_size;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          new_pixel;
    logic [DW-1:0] Pixel_Data;
    logic [MW-1:0] M;
    logic          Image_Done;
    logic          busy;
    logic          cfg_err;

    block_pixel_streamer #(
        .Data_Depth(DW),
        .ADDR_W    (AW),
        .SIZE_W    (SW),
        .M_W       (MW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .img_size  (img_size),
        .blk_size  (blk_size),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .new_pixel (new_pixel),
        .Pixel_Data(Pixel_Data),
        .M         (M),
        .Image_Done(Image_Done),
        .busy      (busy),
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] ram [0:1023];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= ram[mem_addr[9:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor state
    bit mon_on = 1'b0;
    int rd_q[$];
    int np_q[$];
    int first_rd, first_np, last_np, done_cyc, done_cnt, err_cnt, m_bad, exp_m, start_cyc;

    always @(negedge clk) begin
        if (!rst && mon_on) begin
            if (mem_rd_en) begin
                rd_q.push_back(int'(mem_addr));
                if (first_rd < 0) first_rd = cyc;
            end
            if (new_pixel) begin
                np_q.push_back(int'(Pixel_Data));
                if (first_np < 0) first_np = cyc;
                last_np = cyc;
            end
            if (Image_Done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cfg_err) err_cnt++;
            if (busy && (int'(M) != exp_m)) m_bad++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        rd_q.delete();
        np_q.delete();
        first_rd = -1;
        first_np = -1;
        last_np  = -1;
        done_cyc = -1;
        done_cnt = 0;
        err_cnt  = 0;
        m_bad    = 0;
    endtask

    task automatic fill_ram(input bit rnd);
        for (int a = 0; a < 1024; a++) ram[a] = rnd ? 8'($urandom) : a[7:0];
    endtask

    // Stream one image and check it against the block-order model.
    // inj > 0: pulse a conflicting start once that many pixels have been seen.
    task automatic run_image(input int n, input int m, input int exp_chk, input int inj);
        bit ok;
        bit injected;
        int exp_a[$];
        int bad_a, bad_d, k;
        ok = (m != 0) && (n != 0) && (m <= n) && ((n % m) == 0);
        exp_a.delete();
        if (ok) begin
            for (int s = 0; s < n / m; s++)
                for (int b = 0; b < n / m; b++)
                    for (int r = 0; r < m; r++)
                        for (int c = 0; c < m; c++)
                            exp_a.push_back((s * m + r) * n + b * m + c);
        end
        clear_mon();
        exp_m = m;
        injected = 1'b0;
        @(negedge clk); #1;
        start = 1'b1;
        img_size = n[SW-1:0];
        blk_size = m[MW-1:0];
        start_cyc = cyc;
        mon_on = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n * n + 60; i++) begin
            if (done_cnt > 0 || err_cnt > 0) break;
            start = 1'b0;
            if (inj > 0 && !injected && np_q.size() == inj) begin
                start = 1'b1;
                img_size = 10'd4;
                blk_size = 7'd4;
                injected = 1'b1;
            end
            @(negedge clk); #1;
        end
        start = 1'b0;
        chk($sformatf("finish_n%0d_m%0d", n, m), 64'(done_cnt + err_cnt > 0), 64'd1);
        @(negedge clk); #1;
        chk("busy_low_after", 64'(busy), 64'd0);
        repeat (4) @(negedge clk);
        #1;
        mon_on = 1'b0;
        if (ok) begin
            chk("err_cnt", 64'(err_cnt), 64'd0);
            chk("done_cnt", 64'(done_cnt), 64'd1);
            chk("rd_count", 64'(rd_q.size()), 64'(n * n));
            chk("np_count", 64'(np_q.size()), 64'(n * n));
            chk("check_cycles", 64'(first_rd - start_cyc - 1), 64'(exp_chk));
            chk("rd_to_pixel", 64'(first_np - first_rd), 64'd2);
            chk("np_contig", 64'(last_np - first_np), 64'(n * n - 1));
            chk("done_timing", 64'(done_cyc - last_np), 64'd1);
            bad_a = 0;
            bad_d = 0;
            k = (rd_q.size() < exp_a.size()) ? rd_q.size() : exp_a.size();
            for (int i = 0; i < k; i++) if (rd_q[i] != exp_a[i]) bad_a++;
            k = (np_q.size() < exp_a.size()) ? np_q.size() : exp_a.size();
            for (int i = 0; i < k; i++) if (np_q[i] != int'(ram[exp_a[i]])) bad_d++;
            chk("addr_seq_errors", 64'(bad_a), 64'd0);
            chk("data_seq_errors", 64'(bad_d), 64'd0);
            chk("pixel_hold", 64'(Pixel_Data), 64'(ram[exp_a[n * n - 1]]));
        end else begin
            chk("cfg_err_cnt", 64'(err_cnt), 64'd1);
            chk("err_no_reads", 64'(rd_q.size()), 64'd0);
            chk("err_no_pixels", 64'(np_q.size()), 64'd0);
            chk("err_no_done", 64'(done_cnt), 64'd0);
        end
        chk("m_stable", 64'(m_bad), 64'd0);
        chk("m_held", 64'(M), 64'(m));
    endtask

    typedef struct {
        int n;
        int m;
        int exp_chk;
    } vec_t;

    vec_t vecs[10];
    int   seq42[16];

    initial begin
        int bad, n, m, ec;
        rst = 1'b1;
        start = 1'b0;
        img_size = '0;
        blk_size = '0;
        clear_mon();
        exp_m = 0;

        vecs[0] = '{4, 2, 3};
        vecs[1] = '{6, 3, 3};
        vecs[2] = '{5, 2, 0};
        vecs[3] = '{4, 0, 0};
        vecs[4] = '{2, 4, 0};
        vecs[5] = '{4, 4, 2};
        vecs[6] = '{4, 1, 5};
        vecs[7] = '{1, 1, 2};
        vecs[8] = '{12, 3, 5};
        vecs[9] = '{16, 8, 3};
        seq42 = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};

        fill_ram(1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_outs", 64'({mem_rd_en, new_pixel, Image_Done, cfg_err}), 64'd0);
        chk("reset_pix_m", 64'({Pixel_Data, M}), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_image(vecs[i].n, vecs[i].m, vecs[i].exp_chk, 0);
            if (i == 0) begin
                bad = (rd_q.size() == 16) ? 0 : 1;
                for (int j = 0; j < rd_q.size() && j < 16; j++) if (rd_q[j] != seq42[j]) bad++;
                chk("n4m2_literal_seq", 64'(bad), 64'd0);
            end
        end

        // Start while streaming must be ignored
        run_image(8, 2, 5, 10);

        // Asynchronous reset in the middle of a stream
        fill_ram(1'b0);
        clear_mon();
        exp_m = 2;
        @(negedge clk); #1;
        start = 1'b1;
        img_size = 10'd4;
        blk_size = 7'd2;
        mon_on = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 100 && np_q.size() < 5; i++) begin
            @(negedge clk); #1;
        end
        chk("rst_reach_px5", 64'(np_q.size()), 64'd5);
        rst = 1'b1;
        #1;
        mon_on = 1'b0;
        chk("rst_ctrl_zero", 64'({mem_rd_en, new_pixel, Image_Done, busy, cfg_err}), 64'd0);
        chk("rst_addr_zero", 64'(mem_addr), 64'd0);
        chk("rst_pix_zero", 64'(Pixel_Data), 64'd0);
        chk("rst_m_zero", 64'(M), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_image(4, 2, 3, 0);

        // Random geometries and contents against the model
        for (int t = 0; t < 20; t++) begin
            fill_ram(1'b1);
            n = int'($urandom_range(1, 16));
            if ($urandom_range(0, 3) != 0) begin
                do m = int'($urandom_range(1, n)); while ((n % m) != 0);
            end else begin
                m = int'($urandom_range(0, n + 1));
            end
            ec = (m != 0 && m <= n && (n % m) == 0) ? n / m + 1 : 0;
            run_image(n, m, ec, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/block_pixel_streamer.md
Name: block_pixel_streamer

Overview:
- Transmit side of the block-order pixel interface (clk, new_pixel, Pixel_Data, M, Image_Done).
- Reads an N x N image stored raster-order in a synchronous pixel RAM. Streams it as M x M blocks: raster order inside a block, blocks left to right within a strip, strips top to bottom.
- Feeds the DUT and the verification golden model.
- Validates N/M geometry before streaming and signals completion with Image_Done.

Parameters:
- Data_Depth, 8, pixel width in bits
- ADDR_W, 20, pixel RAM address width (N*N <= 2**ADDR_W)
- SIZE_W, 10, width of image side N
- M_W, 7, width of block side M

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request to stream an image; sampled only in IDLE
- img_size  in  SIZE_W  N, image side in pixels; captured on accepted start
- blk_size  in  M_W  M, block side; captured on accepted start
- mem_rd_en  out  1  RAM read strobe
- mem_addr  out  ADDR_W  RAM read address
- mem_rdata  in  Data_Depth  RAM data, valid the cycle after mem_rd_en
- new_pixel  out  1  Pixel_Data valid this cycle
- Pixel_Data  out  Data_Depth  streamed pixel
- M  out  M_W  captured block size, held stable from accepted start until next accepted start
- Image_Done  out  1  one-cycle pulse after the last pixel
- busy  out  1  high in any state other than IDLE
- cfg_err  out  1  one-cycle pulse on rejected geometry

Behaviour:
- Reset (async, any state, including mid-stream): state=IDLE; all outputs 0; all counters, address and pipeline regs 0. An in-flight read is discarded.
- IDLE:
  - start=1 captures N and M (M output updates next cycle), then goes to CHECK.
  - start in any other state is ignored.
- CHECK (iterative subtract):
  - First cycle: rem=N, kpb=0.
  - Each cycle: if M==0, N==0 or M>N -> ERR. Else if rem>=M: rem-=M, kpb+=1. Else rem==0 -> STREAM, else -> ERR.
  - Takes N/M+1 cycles for valid geometry. kpb = blocks per strip.
- ERR: cfg_err=1 for one cycle; no reads, no new_pixel, no Image_Done; -> IDLE.
- STREAM: mem_rd_en=1 every cycle.
  - Counters: col 0..M-1, row 0..M-1, bcol 0..kpb-1, strip 0..kpb-1. addr starts at 0.
  - col<M-1: addr+=1, col+=1.
  - col=M-1, row<M-1: addr+=N-M+1, col=0, row+=1.
  - End of block, bcol<kpb-1: addr-=N*(M-1)-1, bcol+=1.
  - End of block, bcol=kpb-1: addr+=1, bcol=0, strip+=1.
  - Last pixel (strip=bcol=kpb-1, row=col=M-1): issue the read, then -> DRAIN.
  - Address arithmetic is ADDR_W-bit unsigned; no intermediate result leaves 0..N*N-1.
- Pipeline:
  - Read issued in cycle t. mem_rdata registered into Pixel_Data at the end of t+1. new_pixel=1 in cycle t+2.
  - Exactly N*N new_pixel cycles, back-to-back, no gaps.
  - Pixel_Data holds its last value when new_pixel=0.
- DRAIN: waits for the last two pipeline stages to empty, then -> DONE.
- DONE: Image_Done=1 for exactly the cycle after the last new_pixel; -> IDLE.
- Timing:
  - First mem_rd_en occurs the cycle after CHECK ends.
  - Earliest re-accept of start is the cycle after Image_Done.
  - busy falls in the same cycle IDLE is re-entered.
- M==N: single block, output equals raster order. M==1: raster order, kpb=N.

Test Plan:
- N=4, M=2, RAM[a]=a -> mem_addr and Pixel_Data sequence 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15. new_pixel high 16 consecutive cycles, first one 3 cycles after the last CHECK cycle. Image_Done one cycle after pixel 15. M output=2 throughout.
- N=6, M=3 -> CHECK 3 cycles. Output sequence 0,1,2,6,7,8,12,13,14,3,4,5,9,10,11,15,16,17, then strip 2 starting at 18. Total 36 pixels. Output matches the golden-model block reassembly exactly.
- N=5, M=2; N=4, M=0; N=2, M=4 -> each gives one cfg_err pulse, zero mem_rd_en, zero new_pixel, no Image_Done. busy returns to 0.
- N=M=4 and N=4, M=1 -> raster order 0..15 in both cases.
- start pulsed mid-stream with N=8, M=2 -> ignored. Stream completes with 64 pixels and the original M; exactly one Image_Done.
- rst asserted after pixel 5 of an N=4, M=2 stream -> all outputs 0 immediately. A new start after rst release streams a full 16-pixel image starting at addr 0.
